// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Program sequencer for the accumulator microprocessor. Holds the current
// program address and moves it on every clock according to the sequencing
// operation that the decoder returns for that address. It supports stall,
// unconditional and carry-conditional jumps, subroutine call/return through an
// internal return-address stack, and a terminal HALT state.
//
// Parameters
//   ADDR_W      program address width (2^ADDR_W words)
//   STACK_DEPTH return-address stack entries (>= 1)
//   RESET_ADDR  address loaded on reset
//
// Ports
//   clk       in   system clock, rising edge
//   Reset     in   synchronous active-high reset
//   Stall     in   hold all state this cycle, Op ignored
//   Op        in   0 NEXT, 1 JMP, 2 JC, 3 JNC, 4 CALL, 5 RET, 6 HALT, 7 NEXT
//   Target    in   jump/call destination
//   CY        in   carry flag, sampled with Op for JC/JNC
//   Addr      out  current program address (registered)
//   Halted    out  sequencer is in HALT
//   StackErr  out  sticky stack overflow/underflow flag
//   Depth     out  number of valid stack entries
//
// States
//   ST_RUN  | executing: Addr advances per Op unless stalled
//   ST_HALT | stopped: all state frozen until Reset
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int          ADDR_W      = 5,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               Reset,
  input  logic                               Stall,
  input  logic [2:0]                         Op,
  input  logic [ADDR_W-1:0]                  Target,
  input  logic                               CY,
  output logic [ADDR_W-1:0]                  Addr,
  output logic                               Halted,
  output logic                               StackErr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  // Stack pointer width; a single-entry stack still needs a 1-bit index.
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JC   = 3'd2;
  localparam logic [2:0] OP_JNC  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                err_q,   err_d;

  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0]   addr_inc;
  logic [DW-1:0]       depth_m1;
  logic [PW-1:0]       push_ptr;
  logic [PW-1:0]       pop_ptr;
  logic                stack_full;
  logic                stack_empty;
  logic                push;

  // Natural wrap of the ADDR_W-bit adder gives the mod 2^ADDR_W increment.
  assign addr_inc    = addr_q + ADDR_W'(1);
  assign depth_m1    = depth_q - DW'(1);
  // Depth doubles as the stack pointer: next free slot is depth, top is depth-1.
  // The push pointer is only used when not full, so the truncation is safe.
  assign push_ptr    = depth_q[PW-1:0];
  assign pop_ptr     = depth_m1[PW-1:0];
  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;

    if (state_q == ST_RUN && !Stall) begin
      case (Op)
        OP_JMP: begin
          addr_d = Target;
        end
        OP_JC: begin
          addr_d = CY ? Target : addr_inc;
        end
        OP_JNC: begin
          addr_d = CY ? addr_inc : Target;
        end
        OP_CALL: begin
          if (stack_full) begin
            // Overflow: treat as NEXT, keep existing return addresses intact.
            err_d  = 1'b1;
            addr_d = addr_inc;
          end else begin
            push    = 1'b1;
            depth_d = depth_q + DW'(1);
            addr_d  = Target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_d  = 1'b1;
            addr_d = addr_inc;
          end else begin
            addr_d  = stack_q[pop_ptr];
            depth_d = depth_m1;
          end
        end
        OP_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          // NEXT and the unused encoding 7
          addr_d = addr_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      addr_q  <= ADDR_W'(RESET_ADDR);
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage carries no reset: contents are meaningless once Depth is 0,
  // and a pop never clears the entry it reads.
  always_ff @(posedge clk) begin
    if (push && !Reset) begin
      stack_q[push_ptr] <= addr_inc;
    end
  end

  assign Addr     = addr_q;
  assign Halted   = (state_q == ST_HALT);
  assign StackErr = err_q;
  assign Depth    = depth_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program sequencer, the successor of the 5-bit free-running program counter in the accumulator microprocessor. It feeds the program-memory/decoder address and adds stall, unconditional and carry-conditional jumps, subroutine call/return through an internal return-address stack, and a halt state. The decoder output for the instruction at `Addr` drives `Op`/`Target` back into this block, forming a single-cycle fetch loop.

## Interface
- `ADDR_W`, 5: program address width; address space is 2^ADDR_W words.
- `STACK_DEPTH`, 4: return-address stack entries, ≥1.
- `RESET_ADDR`, 0: value loaded into `Addr` on reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `Stall`  in  1  hold all state; `Op` is ignored this cycle.
- `Op`  in  3  sequencing operation for the current instruction: 0 NEXT, 1 JMP, 2 JC, 3 JNC, 4 CALL, 5 RET, 6 HALT, 7 is treated as NEXT.
- `Target`  in  ADDR_W  jump/call destination.
- `CY`  in  1  carry flag from the CY register, used by JC/JNC.
- `Addr`  out  ADDR_W  current program address (registered).
- `Halted`  out  1  the sequencer is in the HALT state.
- `StackErr`  out  1  sticky overflow/underflow flag.
- `Depth`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.

## Operation
- States are RUN and HALT. The only exit from HALT is `Reset`.
- Priority per edge: `Reset` > HALT state > `Stall` > `Op`.
- On `Reset`:
  - `Addr`=RESET_ADDR, state=RUN, `Halted`=0, `StackErr`=0, `Depth`=0.
  - Stack contents are don't-care.
- In HALT, all state holds regardless of `Stall`/`Op`.
- In RUN with `Stall`=1, all state holds.
- In RUN with `Stall`=0, by `Op`:
  - NEXT: `Addr` ← `Addr`+1 mod 2^ADDR_W (max wraps to 0).
  - JMP: `Addr` ← `Target`.
  - JC: `Addr` ← `Target` if `CY`=1, else `Addr`+1.
  - JNC: `Addr` ← `Target` if `CY`=0, else `Addr`+1.
  - CALL, not full: push (`Addr`+1 mod 2^ADDR_W), `Depth`+1, `Addr` ← `Target`.
  - CALL, full (`Depth`=STACK_DEPTH): no push, `StackErr` ← 1, `Addr` ← `Addr`+1.
  - RET, not empty: `Addr` ← top entry, pop, `Depth`−1.
  - RET, empty: `StackErr` ← 1, `Addr` ← `Addr`+1.
  - HALT: state ← HALT, `Halted` ← 1, `Addr` holds.
- `StackErr` clears only on `Reset`.
- The stack is LIFO. Entries are overwritten only by a push, and a pop does not clear the entry.
- `CY` is sampled on the same edge as `Op`. There is no internal flag register.

## Timing
- All outputs are registered and update one clock after the controlling inputs are sampled.
- The effect of an `Op` taken is visible on `Addr` at the next edge. There is no delay slot and no bubble, so jump, call and return each cost one cycle, the same as NEXT.
- `Stall` asserted for N cycles freezes `Addr` for exactly N cycles. The `Op` presented on the first unstalled edge is executed.
- `Reset` asserted concurrently with any `Op`/`Stall`/HALT wins. On the next cycle `Addr`=RESET_ADDR even mid-call (stack abandoned, `Depth`=0).
- A CALL immediately followed by RET (no intervening instruction) returns to call-site+1 on the second edge.
- Combinational path `Addr` → decoder → `Op`/`Target` → next-`Addr` must close in one cycle. The block itself adds no path from `Op` to `Addr` other than through the register.

## Test plan
- Reset then 40 NEXT cycles, defaults: `Addr` runs 0..31, wraps to 0 at cycle 32, and reaches 7 at cycle 39; `Depth`=0 and `StackErr`=0 throughout.
- At `Addr`=3, JC `Target`=20:
  - with `CY`=0: next `Addr`=4.
  - with `CY`=1: next `Addr`=20.
  - JNC mirrors this (`CY`=0 → 20).
- CALL sequence:
  - At `Addr`=2, CALL 10: `Addr`=10, `Depth`=1.
  - At 10, CALL 15: `Addr`=15, `Depth`=2.
  - RET: `Addr`=11, `Depth`=1.
  - RET: `Addr`=3, `Depth`=0.
- Five nested CALLs to 8, 9, 10, 11, 12 from `Addr`=1:
  - The fifth call does not jump: `Addr` at the fifth call site +1, `StackErr`=1, `Depth`=4.
  - A following RET from `Depth`=0 after four RETs also gives `Addr`+1 with `StackErr` still 1.
- `Stall`=1 for 3 cycles at `Addr`=6 with `Op`=JMP 25: `Addr` stays 6 for 3 cycles, then becomes 25 one edge after `Stall` drops.
- HALT at `Addr`=9: `Halted`=1 and `Addr`=9 for 10 cycles despite `Op`=JMP; `Reset` pulse → `Addr`=0, `Halted`=0, `StackErr`=0, `Depth`=0 on the next edge.
